// File: rtl/fp_add_norm_round_pipe.sv
// fp_add_norm_round_pipe
//   Final normalize/round step of the floating-point adder, split into two
//   register stages with valid/ready backpressure.
//   Stage 1 normalizes the raw mantissa sum (carry right-shift or
//   leading-one left-shift). Stage 2 rounds per frm, resolves exceptions and
//   registers the packed result and flags.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   frm                 rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE)
//   sign_in, exp_in     result sign and larger biased exponent
//   mant_in             {hidden, fraction, G, R} before normalization
//   carry_in, sticky_in carry out of mantissa add, alignment sticky
//   ovf_in..dz_in       upstream exception flags
//   out_valid/out_ready output handshake
//   result, flags       packed float and {NV, DZ, OF, UF, NX}
module fp_add_norm_round_pipe #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              frm,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W+2:0]       mant_in,
    input  logic                    carry_in,
    input  logic                    sticky_in,
    input  logic                    ovf_in,
    input  logic                    unf_in,
    input  logic                    inv_in,
    input  logic                    dz_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [4:0]              flags
);

    localparam int M_W   = FRAC_W + 3;
    localparam int E_W   = EXP_W + 2;
    localparam int R_W   = 1 + EXP_W + FRAC_W;
    localparam int CNT_W = $clog2(M_W + 1);

    localparam logic signed [E_W-1:0] E_ONE   = E_W'(1);
    localparam logic signed [E_W-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    // Number of leading zeros of m; M_W when m is zero.
    function automatic logic [CNT_W-1:0] lead_zeros(input logic [M_W-1:0] m);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = M_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n     = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    function automatic logic round_inc(input logic [2:0] mode, input logic s,
                                       input logic lsb, input logic g,
                                       input logic r, input logic st);
        case (mode)
            3'd1:    return 1'b0;
            3'd2:    return s & (g | r | st);
            3'd3:    return ~s & (g | r | st);
            3'd4:    return g;
            default: return g & (r | st | lsb);
        endcase
    endfunction

    // Saturated result on overflow: infinity or largest finite, by mode and sign.
    function automatic logic [R_W-1:0] ovf_value(input logic [2:0] mode, input logic s);
        logic [R_W-1:0] inf_v;
        logic [R_W-1:0] max_v;
        inf_v = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        max_v = {s, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        case (mode)
            3'd1:    return max_v;
            3'd2:    return s ? inf_v : max_v;
            3'd3:    return s ? max_v : inf_v;
            default: return inf_v;
        endcase
    endfunction

    // Handshake / stage advance
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_load;
    logic s1_load;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // ---------------- stage 1: normalize ----------------
    logic [CNT_W-1:0]      lz;
    logic signed [E_W-1:0] exp_ext;
    logic [M_W-1:0]        s1_mant_d,   s1_mant_q;
    logic signed [E_W-1:0] s1_exp_d,    s1_exp_q;
    logic                  s1_sticky_d, s1_sticky_q;
    logic                  s1_sign_q;
    logic [2:0]            s1_frm_q;
    logic                  s1_ovf_q, s1_unf_q, s1_inv_q, s1_dz_q;

    always_comb begin
        lz      = lead_zeros(mant_in);
        exp_ext = {2'b00, exp_in};
        if (carry_in) begin
            s1_mant_d   = {1'b1, mant_in[M_W-1:1]};
            s1_sticky_d = sticky_in | mant_in[0];
            s1_exp_d    = exp_ext + E_ONE;
        end else begin
            // A zero mantissa shifts out completely, leaving the hidden bit clear.
            s1_mant_d   = mant_in << lz;
            s1_sticky_d = sticky_in;
            s1_exp_d    = exp_ext - $signed({{(E_W-CNT_W){1'b0}}, lz});
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_mant_q   <= s1_mant_d;
            s1_exp_q    <= s1_exp_d;
            s1_sticky_q <= s1_sticky_d;
            s1_sign_q   <= sign_in;
            s1_frm_q    <= frm;
            s1_ovf_q    <= ovf_in;
            s1_unf_q    <= unf_in;
            s1_inv_q    <= inv_in;
            s1_dz_q     <= dz_in;
        end
    end

    // ---------------- stage 2: round and resolve exceptions ----------------
    logic                  is_zero;
    logic                  g_bit, r_bit, lsb_bit, inc;
    logic [FRAC_W:0]       frac_sum;
    logic signed [E_W-1:0] exp_rnd;
    logic                  is_ovf, is_unf, nx;
    logic [R_W-1:0]        result_d, result_q;
    logic [4:0]            flags_d,  flags_q;

    always_comb begin
        is_zero  = !s1_mant_q[M_W-1];
        g_bit    = s1_mant_q[1];
        r_bit    = s1_mant_q[0];
        lsb_bit  = s1_mant_q[2];
        inc      = round_inc(s1_frm_q, s1_sign_q, lsb_bit, g_bit, r_bit, s1_sticky_q);
        frac_sum = {1'b0, s1_mant_q[FRAC_W+1:2]} + {{FRAC_W{1'b0}}, inc};
        // Fraction carry-out leaves a zero fraction and bumps the exponent.
        exp_rnd  = s1_exp_q + $signed({{(E_W-1){1'b0}}, frac_sum[FRAC_W]});
        nx       = g_bit | r_bit | s1_sticky_q;
        is_ovf   = s1_ovf_q || (!is_zero && (exp_rnd >= EXP_MAX));
        is_unf   = s1_unf_q || (!is_zero && (exp_rnd[E_W-1] || (exp_rnd == '0)));

        result_d = {s1_sign_q, exp_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
        flags_d  = {1'b0, s1_dz_q, 2'b00, nx};
        if (s1_inv_q) begin
            result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            flags_d  = {1'b1, s1_dz_q, 3'b000};
        end else if (is_ovf) begin
            result_d = ovf_value(s1_frm_q, s1_sign_q);
            flags_d  = {1'b0, s1_dz_q, 3'b101};
        end else if (is_unf) begin
            result_d = {s1_sign_q, {(R_W-1){1'b0}}};
            flags_d  = {1'b0, s1_dz_q, 3'b011};
        end else if (is_zero) begin
            result_d = {s1_sign_q, {(R_W-1){1'b0}}};
            flags_d  = {1'b0, s1_dz_q, 3'b000};
        end
    end

    // ---------------- control and output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            if (s1_load) s1_valid_q <= in_valid;
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    result_q <= result_d;
                    flags_q  <= flags_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_norm_round_pipe.sv
// Testbench for fp_add_norm_round_pipe (FP16 configuration).
// Directed cases with fixed expected encodings, backpressure and reset
// scenarios, then randomized traffic scored against a value-level model.
module tb_fp_add_norm_round_pipe;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  frm;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [12:0] mant_in;
    logic        carry_in, sticky_in, ovf_in, unf_in, inv_in, dz_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    fp_add_norm_round_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .frm(frm), .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
        .carry_in(carry_in), .sticky_in(sticky_in), .ovf_in(ovf_in),
        .unf_in(unf_in), .inv_in(inv_in), .dz_in(dz_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    logic [20:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Value-level model: locate the MSB of the full sum, take 11 significand
    // bits, derive G/R/S from what lies below, round, then classify.
    function automatic logic [20:0] ref_model(input logic [2:0] m, input logic s,
                                              input logic [4:0] e, input logic [12:0] mt,
                                              input logic c, input logic st, input logic ov,
                                              input logic un, input logic iv, input logic dz);
        longint v, w, sig;
        int     p, ex, mode;
        logic   g, r, sk, inc, nx, use_inf, is_zero;
        mode = (m > 3'd4) ? 0 : int'(m);
        if (iv) return {1'b1, dz, 3'b000, 16'h7E00};
        v = longint'(mt);
        if (c) v = v + (64'sd1 << 13);
        is_zero = (v == 0);
        g = 1'b0; r = 1'b0; sk = 1'b0; sig = 0; ex = 0;
        if (!is_zero) begin
            p = 13;
            while (((v >> p) & 1) == 0) p--;
            ex  = int'(e) + p - 12;
            w   = v << 16;
            sig = w >> (p + 6);
            g   = ((w >> (p + 5)) & 1) != 0;
            r   = ((w >> (p + 4)) & 1) != 0;
            sk  = st || ((w & ((64'sd1 << (p + 4)) - 1)) != 0);
            case (mode)
                1:       inc = 1'b0;
                2:       inc = s && (g || r || sk);
                3:       inc = !s && (g || r || sk);
                4:       inc = g;
                default: inc = g && (r || sk || ((sig & 1) != 0));
            endcase
            sig = sig + (inc ? 1 : 0);
            if (sig == 2048) begin
                sig = 1024;
                ex  = ex + 1;
            end
        end
        nx = g || r || sk;
        use_inf = (mode == 0) || (mode == 4) || (mode == 2 && s) || (mode == 3 && !s);
        if (ov || (!is_zero && ex >= 31))
            return {1'b0, dz, 3'b101, use_inf ? {s, 5'h1f, 10'h000} : {s, 5'h1e, 10'h3ff}};
        if (un || (!is_zero && ex <= 0))
            return {1'b0, dz, 3'b011, s, 15'h0000};
        if (is_zero)
            return {1'b0, dz, 3'b000, s, 15'h0000};
        return {1'b0, dz, 2'b00, nx, s, ex[4:0], sig[9:0]};
    endfunction

    // Output scoreboard, hold-stability watch and input capture, all sampled
    // on the falling edge.
    logic        hold_v = 1'b0;
    logic [20:0] hold_val;
    logic [20:0] mon_e;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check_eq("hold_stable", {11'd0, flags, result}, {11'd0, hold_val});
            hold_v   = out_valid && !out_ready;
            hold_val = {flags, result};
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("model_result", {16'd0, result}, {16'd0, mon_e[15:0]});
                    check_eq("model_flags", {27'd0, flags}, {27'd0, mon_e[20:16]});
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(frm, sign_in, exp_in, mant_in, carry_in,
                                          sticky_in, ovf_in, unf_in, inv_in, dz_in));
        end
    end

    task automatic set_beat(input logic [2:0] m, input logic s, input logic [4:0] e,
                            input logic [12:0] mt, input logic c, input logic st,
                            input logic ov, input logic un, input logic iv, input logic dz);
        frm = m; sign_in = s; exp_in = e; mant_in = mt; carry_in = c;
        sticky_in = st; ovf_in = ov; unf_in = un; inv_in = iv; dz_in = dz;
    endtask

    // Starts and ends just after a rising edge; returns after the accepting edge.
    task automatic push_beat();
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("accept", {31'd0, ok}, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [2:0] m, input logic s,
                           input logic [4:0] e, input logic [12:0] mt, input logic iv,
                           input logic [15:0] want_res, input logic [4:0] want_fl);
        int k;
        out_ready = 1'b1;
        set_beat(m, s, e, mt, 1'b0, 1'b0, 1'b0, 1'b0, iv, 1'b0);
        push_beat();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        check_eq({tag, "_lat"}, k, 2);
        check_eq({tag, "_res"}, {16'd0, result}, {16'd0, want_res});
        check_eq({tag, "_flags"}, {27'd0, flags}, {27'd0, want_fl});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        int acc, idx, n0;
        logic accepted;
        logic [4:0] bp_exp [4];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_beat(3'd0, 1'b0, 5'd0, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 0);
        check_eq("rst_result", {16'd0, result}, 0);
        check_eq("rst_flags", {27'd0, flags}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        // Directed values
        run_one("one",      3'd0, 1'b0, 5'd15, 13'b1_0000000000_00, 1'b0, 16'h3C00, 5'h00);
        run_one("tie_odd",  3'd0, 1'b0, 5'd15, 13'b1_0000000001_10, 1'b0, 16'h3C02, 5'h01);
        run_one("tie_even", 3'd0, 1'b0, 5'd15, 13'b1_0000000000_10, 1'b0, 16'h3C00, 5'h01);
        run_one("tie_rup",  3'd3, 1'b0, 5'd15, 13'b1_0000000000_10, 1'b0, 16'h3C01, 5'h01);
        run_one("rnd_carry",3'd0, 1'b0, 5'd15, 13'h1FFF,            1'b0, 16'h4000, 5'h01);
        run_one("ovf_rne",  3'd0, 1'b0, 5'd30, 13'h1FFF,            1'b0, 16'h7C00, 5'h05);
        run_one("ovf_rtz",  3'd1, 1'b0, 5'd30, 13'h1FFF,            1'b0, 16'h7BFF, 5'h01);
        run_one("norm_l10", 3'd0, 1'b0, 5'd15, 13'b0_0000000001_00, 1'b0, 16'h1400, 5'h00);
        run_one("unf",      3'd0, 1'b0, 5'd3,  13'b0_0000000001_00, 1'b0, 16'h0000, 5'h03);
        run_one("inv",      3'd0, 1'b0, 5'd3,  13'b0_0000000001_00, 1'b1, 16'h7E00, 5'h10);
        run_one("zero",     3'd0, 1'b1, 5'd9,  13'd0,               1'b0, 16'h8000, 5'h00);
        run_one("ovf_rdn",  3'd2, 1'b1, 5'd30, 13'h1FFF,            1'b0, 16'hFC00, 5'h05);

        // Backpressure: four beats offered while the output is stalled
        bp_exp = '{5'd10, 5'd11, 5'd12, 5'd13};
        n0 = n_out; acc = 0; idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_beat(3'd0, 1'b0, bp_exp[idx], 13'b1_0000000000_00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                if (idx < 3) idx++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("bp_accepted", acc, 2);
        @(negedge clk);
        check_eq("bp_in_ready", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && acc < 4; c++) begin
            set_beat(3'd0, 1'b0, bp_exp[idx], 13'b1_0000000000_00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                if (idx < 3) idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain("bp_drain");
        check_eq("bp_out_count", n_out - n0, 4);

        // Reset with two beats in flight
        out_ready = 1'b0;
        set_beat(3'd0, 1'b0, 5'd20, 13'b1_0101010101_00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_beat();
        set_beat(3'd0, 1'b0, 5'd21, 13'b1_0101010101_00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_beat();
        check_eq("pre_rst_valid", {31'd0, out_valid}, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 0);
        check_eq("mid_rst_result", {16'd0, result}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("post_rst_idle", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;
        run_one("post_rst", 3'd0, 1'b0, 5'd15, 13'b1_0000000000_00, 1'b0, 16'h3C00, 5'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: mant_in = 13'($urandom);
                    1: mant_in = 13'($urandom) & 13'((32'd1 << $urandom_range(0, 12)) - 1);
                    2: mant_in = {11'h7FF, 2'($urandom)};
                    default: mant_in = 13'($urandom) | 13'h1000;
                endcase
                frm       = 3'($urandom);
                sign_in   = 1'($urandom);
                exp_in    = 5'($urandom);
                carry_in  = ($urandom_range(0, 3) == 0);
                sticky_in = 1'($urandom);
                ovf_in    = ($urandom_range(0, 15) == 0);
                unf_in    = ($urandom_range(0, 15) == 0);
                inv_in    = ($urandom_range(0, 15) == 0);
                dz_in     = ($urandom_range(0, 7) == 0);
                in_valid  = 1'b1;
            end
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
